// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage RV32I-format pipeline.
//   Single-cycle ALU ops (add/sub/and/or/addi), lw/sw address generation and
//   beq resolution land in the EX_MEM register at the next edge. sll/sra with
//   a non-zero shift amount use a 1-bit-per-cycle serial shifter. ex_stall is
//   held high while the shift runs so that upstream stages hold.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   *_control               one-hot op select from the controller
//   A/B_ID_EX_data          source operands (B also supplies store data and shamt)
//   ID_EX_immediate_data    sign-extended immediate
//   ID_EX_destination_reg   rd
//   ID_EX_pc                PC of the instruction in EX
//   EX_MEM_*                registered EX_MEM pipeline outputs
//   branch_taken/target     registered beq resolution (one-cycle pulse)
//   ex_stall                high while the serial shift is in progress
module execute_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_control,
  input  logic                  sub_control,
  input  logic                  and_control,
  input  logic                  or_control,
  input  logic                  addi_control,
  input  logic                  sll_control,
  input  logic                  sra_control,
  input  logic                  beq_control,
  input  logic                  sw_control,
  input  logic                  lw_control,
  input  logic [DATA_WIDTH-1:0] A_ID_EX_data,
  input  logic [DATA_WIDTH-1:0] B_ID_EX_data,
  input  logic [DATA_WIDTH-1:0] ID_EX_immediate_data,
  input  logic [4:0]            ID_EX_destination_reg,
  input  logic [ADDR_WIDTH-1:0] ID_EX_pc,
  output logic [DATA_WIDTH-1:0] EX_MEM_alu_result,
  output logic [DATA_WIDTH-1:0] EX_MEM_store_data,
  output logic [4:0]            EX_MEM_destination_reg,
  output logic                  EX_MEM_reg_write,
  output logic                  EX_MEM_mem_read,
  output logic                  EX_MEM_mem_write,
  output logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  ex_stall
);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
  } ex_mem_t;

  state_t                 state, state_nxt;
  ex_mem_t                ex_mem, ex_mem_nxt;
  logic [DATA_WIDTH-1:0]  sh_val, sh_val_nxt, sh_step;
  logic [SHAMT_WIDTH-1:0] sh_cnt, sh_cnt_nxt;
  logic [4:0]             sh_rd, sh_rd_nxt;
  logic                   sh_sra, sh_sra_nxt;

  logic [9:0]             ctrl;
  logic                   one_hot;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  addr_sum;

  assign ctrl    = {lw_control, sw_control, beq_control, sra_control, sll_control,
                    addi_control, or_control, and_control, sub_control, add_control};
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign one_hot  = (ctrl != 10'd0) && ((ctrl & (ctrl - 10'd1)) == 10'd0);
  assign shamt    = B_ID_EX_data[SHAMT_WIDTH-1:0];
  assign addr_sum = A_ID_EX_data + ID_EX_immediate_data;
  // One serial step: sra replicates the sign bit, sll zero-fills.
  assign sh_step  = sh_sra ? {sh_val[DATA_WIDTH-1], sh_val[DATA_WIDTH-1:1]}
                           : {sh_val[DATA_WIDTH-2:0], 1'b0};

  always_comb begin
    state_nxt  = state;
    ex_mem_nxt = '0;
    sh_val_nxt = sh_val;
    sh_cnt_nxt = sh_cnt;
    sh_rd_nxt  = sh_rd;
    sh_sra_nxt = sh_sra;
    case (state)
      IDLE: begin
        if (one_hot) begin
          ex_mem_nxt.rd        = ID_EX_destination_reg;
          ex_mem_nxt.reg_write = 1'b1;
          if (add_control)       ex_mem_nxt.alu_result = A_ID_EX_data + B_ID_EX_data;
          else if (sub_control)  ex_mem_nxt.alu_result = A_ID_EX_data - B_ID_EX_data;
          else if (and_control)  ex_mem_nxt.alu_result = A_ID_EX_data & B_ID_EX_data;
          else if (or_control)   ex_mem_nxt.alu_result = A_ID_EX_data | B_ID_EX_data;
          else if (addi_control) ex_mem_nxt.alu_result = addr_sum;
          else if (lw_control) begin
            ex_mem_nxt.alu_result = addr_sum;
            ex_mem_nxt.mem_read   = 1'b1;
          end else if (sw_control) begin
            ex_mem_nxt.alu_result = addr_sum;
            ex_mem_nxt.store_data = B_ID_EX_data;
            ex_mem_nxt.mem_write  = 1'b1;
            ex_mem_nxt.reg_write  = 1'b0;
          end else if (beq_control) begin
            ex_mem_nxt.reg_write     = 1'b0;
            ex_mem_nxt.branch_taken  = (A_ID_EX_data == B_ID_EX_data);
            ex_mem_nxt.branch_target = ID_EX_pc + ID_EX_immediate_data[ADDR_WIDTH-1:0];
          end else if (shamt == '0) begin
            ex_mem_nxt.alu_result = A_ID_EX_data;
          end else begin
            // Multi-cycle shift: latch operands and emit a bubble this edge.
            ex_mem_nxt = '0;
            state_nxt  = SHIFT;
            sh_val_nxt = A_ID_EX_data;
            sh_cnt_nxt = shamt;
            sh_rd_nxt  = ID_EX_destination_reg;
            sh_sra_nxt = sra_control;
          end
          if (ID_EX_destination_reg == 5'd0) ex_mem_nxt.reg_write = 1'b0;
        end
      end
      SHIFT: begin
        sh_val_nxt = sh_step;
        sh_cnt_nxt = sh_cnt - SHAMT_WIDTH'(1);
        if (sh_cnt == SHAMT_WIDTH'(1)) begin
          ex_mem_nxt.alu_result = sh_step;
          ex_mem_nxt.rd         = sh_rd;
          ex_mem_nxt.reg_write  = (sh_rd != 5'd0);
          state_nxt             = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ex_mem <= '0;
      sh_val <= '0;
      sh_cnt <= '0;
      sh_rd  <= '0;
      sh_sra <= 1'b0;
    end else begin
      state  <= state_nxt;
      ex_mem <= ex_mem_nxt;
      sh_val <= sh_val_nxt;
      sh_cnt <= sh_cnt_nxt;
      sh_rd  <= sh_rd_nxt;
      sh_sra <= sh_sra_nxt;
    end
  end

  assign EX_MEM_alu_result      = ex_mem.alu_result;
  assign EX_MEM_store_data      = ex_mem.store_data;
  assign EX_MEM_destination_reg = ex_mem.rd;
  assign EX_MEM_reg_write       = ex_mem.reg_write;
  assign EX_MEM_mem_read        = ex_mem.mem_read;
  assign EX_MEM_mem_write       = ex_mem.mem_write;
  assign branch_taken           = ex_mem.branch_taken;
  assign branch_target          = ex_mem.branch_target;
  assign ex_stall               = (state == SHIFT);

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage plus hand-written
// multi-cycle sequences for the serial shifter and reset-during-shift.
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  ctrl;
  logic [31:0] a, b, imm;
  logic [4:0]  rd;
  logic [9:0]  pc;
  logic [31:0] res, st;
  logic [4:0]  ord;
  logic        rw, mr, mw, bt, stall;
  logic [9:0]  tgt;

  int checks = 0;
  int errors = 0;

  // ctrl bit order: 0 add,1 sub,2 and,3 or,4 addi,5 sll,6 sra,7 beq,8 sw,9 lw
  localparam logic [9:0] ADD = 10'd1,   SUB = 10'd2,   AND = 10'd4,  OR = 10'd8;
  localparam logic [9:0] ADDI = 10'd16, SLL = 10'd32,  SRA = 10'd64;
  localparam logic [9:0] BEQ = 10'd128, SW = 10'd256,  LW = 10'd512;

  execute_stage dut (
    .clock(clock), .reset(reset),
    .add_control(ctrl[0]), .sub_control(ctrl[1]), .and_control(ctrl[2]),
    .or_control(ctrl[3]), .addi_control(ctrl[4]), .sll_control(ctrl[5]),
    .sra_control(ctrl[6]), .beq_control(ctrl[7]), .sw_control(ctrl[8]),
    .lw_control(ctrl[9]),
    .A_ID_EX_data(a), .B_ID_EX_data(b), .ID_EX_immediate_data(imm),
    .ID_EX_destination_reg(rd), .ID_EX_pc(pc),
    .EX_MEM_alu_result(res), .EX_MEM_store_data(st),
    .EX_MEM_destination_reg(ord), .EX_MEM_reg_write(rw),
    .EX_MEM_mem_read(mr), .EX_MEM_mem_write(mw),
    .branch_taken(bt), .branch_target(tgt), .ex_stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [9:0]  ctrl;
    logic [31:0] a, b, imm;
    logic [4:0]  rd;
    logic [9:0]  pc;
    logic [31:0] e_res, e_st;
    logic [4:0]  e_rd;
    logic        e_rw, e_mr, e_mw, e_bt;
    logic [9:0]  e_tgt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [31:0] ii, input logic [4:0] ri, input logic [9:0] pi);
    ctrl = c; a = ai; b = bi; imm = ii; rd = ri; pc = pi;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " res"}, res, 32'd0);
    chk({name, " st"}, st, 32'd0);
    chk({name, " rd"}, {27'd0, ord}, 32'd0);
    chk({name, " flags"}, {27'd0, rw, mr, mw, bt, stall}, 32'd0);
    chk({name, " tgt"}, {22'd0, tgt}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int n;
    reset = 1'b1;
    drive('0, '0, '0, '0, '0, '0);

    vecs.push_back('{"add",     ADD,  32'd7, 32'd5, 32'd0, 5'd3, 10'd0, 32'd12, 32'd0, 5'd3, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"sub",     SUB,  32'd0, 32'd1, 32'd0, 5'd4, 10'd0, 32'hFFFFFFFF, 32'd0, 5'd4, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"addi",    ADDI, 32'h7FFFFFFF, 32'd0, 32'd1, 5'd6, 10'd0, 32'h80000000, 32'd0, 5'd6, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"and",     AND,  32'hF0F0, 32'hFF00, 32'd0, 5'd7, 10'd0, 32'hF000, 32'd0, 5'd7, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"or",      OR,   32'hF0F0, 32'hFF00, 32'd0, 5'd8, 10'd0, 32'hFFF0, 32'd0, 5'd8, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"sw",      SW,   32'h100, 32'hAB, 32'd8, 5'd0, 10'd0, 32'h108, 32'hAB, 5'd0, 0, 0, 1, 0, 10'd0});
    vecs.push_back('{"lw_rd0",  LW,   32'h200, 32'd0, 32'hFFFFFFFC, 5'd0, 10'd0, 32'h1FC, 32'd0, 5'd0, 0, 1, 0, 0, 10'd0});
    vecs.push_back('{"lw",      LW,   32'h10, 32'd0, 32'd4, 5'd9, 10'd0, 32'h14, 32'd0, 5'd9, 1, 1, 0, 0, 10'd0});
    vecs.push_back('{"beq_t",   BEQ,  32'd9, 32'd9, 32'hFFFFFFF8, 5'd0, 10'd20, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 10'd12});
    vecs.push_back('{"beq_nt",  BEQ,  32'd9, 32'd8, 32'hFFFFFFF8, 5'd0, 10'd20, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 10'd12});
    vecs.push_back('{"beq_wrap",BEQ,  32'd3, 32'd3, 32'd10, 5'd0, 10'd1020, 32'd0, 32'd0, 5'd0, 0, 0, 0, 1, 10'd6});
    vecs.push_back('{"none",    10'd0,32'd7, 32'd5, 32'd0, 5'd3, 10'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 10'd0});
    vecs.push_back('{"multi",   ADD | SUB, 32'd7, 32'd5, 32'd0, 5'd3, 10'd0, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 10'd0});
    vecs.push_back('{"sll0",    SLL,  32'h1234, 32'h20, 32'd0, 5'd2, 10'd0, 32'h1234, 32'd0, 5'd2, 1, 0, 0, 0, 10'd0});
    vecs.push_back('{"add_rd0", ADD,  32'd7, 32'd5, 32'd0, 5'd0, 10'd0, 32'd12, 32'd0, 5'd0, 0, 0, 0, 0, 10'd0});

    step();
    step();
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].rd, vecs[i].pc);
      step();
      chk({vecs[i].name, " res"}, res, vecs[i].e_res);
      chk({vecs[i].name, " st"}, st, vecs[i].e_st);
      chk({vecs[i].name, " rd"}, {27'd0, ord}, {27'd0, vecs[i].e_rd});
      chk({vecs[i].name, " flags"}, {28'd0, rw, mr, mw, bt},
          {28'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_bt});
      chk({vecs[i].name, " tgt"}, {22'd0, tgt}, {22'd0, vecs[i].e_tgt});
      chk({vecs[i].name, " stall"}, {31'd0, stall}, 32'd0);
    end

    // sra by 4: four stall cycles with bubbles, inputs ignored meanwhile.
    @(negedge clock);
    drive(SRA, 32'h80000000, 32'd4, 32'd0, 5'd5, 10'd0);
    step();
    chk("sra e0 stall", {31'd0, stall}, 32'd1);
    chk("sra e0 bubble", {res[31:1], rw}, 32'd0);
    @(negedge clock);
    drive(ADD, 32'd1, 32'd1, 32'd0, 5'd1, 10'd0);
    n = 1;
    for (int k = 0; k < 40 && stall; k++) begin
      step();
      if (stall) begin
        n++;
        chk("sra bubble", {res[31:1], rw}, 32'd0);
      end
    end
    chk("sra stall cycles", n, 32'd4);
    chk("sra res", res, 32'hF8000000);
    chk("sra rw/rd", {26'd0, rw, ord}, {26'd0, 1'b1, 5'd5});
    @(negedge clock);
    drive('0, '0, '0, '0, '0, '0);

    // sll by 31 runs to completion.
    @(negedge clock);
    drive(SLL, 32'd1, 32'd31, 32'd0, 5'd7, 10'd0);
    step();
    @(negedge clock);
    drive('0, '0, '0, '0, '0, '0);
    n = stall ? 1 : 0;
    for (int k = 0; k < 60 && stall; k++) begin
      step();
      if (stall) n++;
    end
    chk("sll31 stall cycles", n, 32'd31);
    chk("sll31 res", res, 32'h80000000);
    chk("sll31 rw/rd", {26'd0, rw, ord}, {26'd0, 1'b1, 5'd7});

    // sll by 31 aborted by reset at stall cycle 10.
    @(negedge clock);
    drive(SLL, 32'd1, 32'd31, 32'd0, 5'd7, 10'd0);
    step();
    @(negedge clock);
    drive('0, '0, '0, '0, '0, '0);
    for (int k = 0; k < 9; k++) step();
    chk("abort pre stall", {31'd0, stall}, 32'd1);
    @(negedge clock);
    reset = 1'b1;
    step();
    chk_all_zero("abort reset");
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (rw || stall || res != 32'd0) n++;
    end
    chk("abort no write", n, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
